// File: rtl/wb_ddr3_pkg.sv
// Shared types and lane helpers for the WISHBONE-to-DDR3 line bridge.
// A line is 16 bytes, split into four 32-bit lanes selected by address bits [3:2].
package wb_ddr3_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_RESP
  } state_t;

  localparam int LINE_BYTES = 16;
  localparam int LANES      = 4;
  localparam int LINE_W     = LINE_BYTES * 8;

  function automatic logic [LINE_BYTES-1:0] lane_mask(input logic [3:0] sel,
                                                      input logic [1:0] lane);
    logic [LINE_BYTES-1:0] m;
    m = '0;
    m[{lane, 2'b00} +: 4] = sel;
    return m;
  endfunction

  function automatic logic [31:0] lane_word(input logic [LINE_W-1:0] line,
                                            input logic [1:0]        lane);
    return line[{lane, 5'b00000} +: 32];
  endfunction

  function automatic logic [LINE_W-1:0] lane_replicate(input logic [31:0] w);
    return {LANES{w}};
  endfunction

  function automatic logic [LINE_W-1:0] byte_merge(input logic [LINE_W-1:0]     old_line,
                                                   input logic [LINE_W-1:0]     new_line,
                                                   input logic [LINE_BYTES-1:0] mask);
    logic [LINE_W-1:0] r;
    r = old_line;
    for (int b = 0; b < LINE_BYTES; b++) begin
      if (mask[b]) r[8*b +: 8] = new_line[8*b +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/ddr3_line_buf.sv
// One-line read buffer: 128-bit data, tag and valid, with whole-line load,
// byte-merge of write data into a matching line, and a tag hit compare.
module ddr3_line_buf
  import wb_ddr3_pkg::*;
#(
  parameter int TAG_W = 24
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [TAG_W-1:0]      lookup_tag_i,
  output logic                  hit_o,
  output logic [LINE_W-1:0]     data_o,
  input  logic [TAG_W-1:0]      tag_i,
  input  logic                  load_i,
  input  logic [LINE_W-1:0]     load_data_i,
  input  logic                  merge_i,
  input  logic [LINE_W-1:0]     merge_data_i,
  input  logic [LINE_BYTES-1:0] merge_mask_i,
  input  logic                  inval_i
);

  logic [LINE_W-1:0] data_q, data_d;
  logic [TAG_W-1:0]  tag_q, tag_d;
  logic              valid_q, valid_d;

  always_comb begin
    data_d  = data_q;
    tag_d   = tag_q;
    valid_d = valid_q;
    if (inval_i) begin
      valid_d = 1'b0;
    end else if (load_i) begin
      data_d  = load_data_i;
      tag_d   = tag_i;
      valid_d = 1'b1;
    end else if (merge_i && valid_q && (tag_q == tag_i)) begin
      // Writes to the buffered line keep it coherent with DDR.
      data_d = byte_merge(data_q, merge_data_i, merge_mask_i);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) valid_q <= 1'b0;
    else       valid_q <= valid_d;
  end

  always_ff @(posedge clk_i) begin
    data_q <= data_d;
    tag_q  <= tag_d;
  end

  assign hit_o  = valid_q && (tag_q == lookup_tag_i);
  assign data_o = data_q;

endmodule

// File: rtl/wb_ddr3_line_bridge.sv
// WISHBONE classic (32-bit) to DDR3 128-bit line port bridge with a one-line
// read buffer, one outstanding DDR request and a per-access timeout.
module wb_ddr3_line_bridge
  import wb_ddr3_pkg::*;
#(
  parameter int ADDR_W   = 28,
  parameter int TIMEOUT  = 1023,
  parameter int LINE_BUF = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  wb_cyc_i,
  input  logic                  wb_stb_i,
  input  logic                  wb_we_i,
  input  logic [31:0]           wb_adr_i,
  input  logic [31:0]           wb_dat_i,
  input  logic [3:0]            wb_sel_i,
  output logic                  wb_ack_o,
  output logic                  wb_err_o,
  output logic [31:0]           wb_dat_o,
  output logic                  inport_rd_o,
  output logic [LINE_BYTES-1:0] inport_wr_o,
  output logic [31:0]           inport_addr_o,
  output logic [LINE_W-1:0]     inport_write_data_o,
  input  logic                  inport_accept_i,
  input  logic                  inport_ack_i,
  input  logic                  inport_error_i,
  input  logic [LINE_W-1:0]     inport_read_data_i
);

  localparam int TAG_W = ADDR_W - 4;
  localparam int TMO_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = (TIMEOUT > 0) ? TMO_W'(TIMEOUT - 1) : '0;

  state_t                state_q, state_d;
  logic                  ack_q, ack_d;
  logic                  err_q, err_d;
  logic [31:0]           dat_q, dat_d;
  logic                  rd_q, rd_d;
  logic [LINE_BYTES-1:0] wr_q, wr_d;
  logic [31:0]           addr_q, addr_d;
  logic [LINE_W-1:0]     wdata_q, wdata_d;
  logic                  abort_q, abort_d;
  logic                  resp_err_q, resp_err_d;
  logic [TMO_W-1:0]      tmo_q, tmo_d;

  logic [1:0]            lane_q, lane_d;
  logic                  we_q, we_d;
  logic [LINE_BYTES-1:0] mask_q, mask_d;
  logic [31:0]           resp_dat_q, resp_dat_d;

  logic                  buf_load, buf_merge, buf_inval;
  logic                  buf_hit_raw, buf_hit;
  logic [LINE_W-1:0]     buf_data;

  logic                  bus_req, out_of_range, zero_wr, tmo_expire;
  logic [1:0]            lane_in;
  logic                  unused_adr_bits;

  assign bus_req      = wb_cyc_i && wb_stb_i;
  assign out_of_range = (wb_adr_i >> ADDR_W) != 32'd0;
  assign zero_wr      = wb_we_i && (wb_sel_i == 4'h0);
  assign lane_in      = wb_adr_i[3:2];
  assign buf_hit      = (LINE_BUF != 0) && buf_hit_raw;
  assign tmo_expire   = (TIMEOUT != 0) && (tmo_q == TMO_LAST);
  assign unused_adr_bits = ^wb_adr_i[1:0];

  ddr3_line_buf #(
    .TAG_W(TAG_W)
  ) u_line_buf (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .lookup_tag_i (wb_adr_i[ADDR_W-1:4]),
    .hit_o        (buf_hit_raw),
    .data_o       (buf_data),
    .tag_i        (addr_q[ADDR_W-1:4]),
    .load_i       (buf_load),
    .load_data_i  (inport_read_data_i),
    .merge_i      (buf_merge),
    .merge_data_i (wdata_q),
    .merge_mask_i (mask_q),
    .inval_i      (buf_inval)
  );

  always_comb begin
    state_d    = state_q;
    ack_d      = 1'b0;
    err_d      = 1'b0;
    dat_d      = '0;
    rd_d       = rd_q;
    wr_d       = wr_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    abort_d    = abort_q;
    resp_err_d = resp_err_q;
    tmo_d      = tmo_q;
    lane_d     = lane_q;
    we_d       = we_q;
    mask_d     = mask_q;
    resp_dat_d = resp_dat_q;
    buf_load   = 1'b0;
    buf_merge  = 1'b0;
    buf_inval  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (bus_req) begin
          abort_d    = 1'b0;
          resp_err_d = 1'b0;
          state_d    = ST_RESP;
          if (out_of_range) begin
            resp_err_d = 1'b1;
          end else if (!wb_we_i && buf_hit) begin
            resp_dat_d = lane_word(buf_data, lane_in);
          end else if (!zero_wr) begin
            state_d = ST_REQ;
            lane_d  = lane_in;
            we_d    = wb_we_i;
            mask_d  = lane_mask(wb_sel_i, lane_in);
            addr_d  = {wb_adr_i[31:4], 4'h0};
            wdata_d = lane_replicate(wb_dat_i);
            rd_d    = !wb_we_i;
            wr_d    = wb_we_i ? lane_mask(wb_sel_i, lane_in) : '0;
          end
        end
      end

      // A request is never withdrawn, even if the master abandons the cycle.
      ST_REQ: begin
        if (!wb_cyc_i) abort_d = 1'b1;
        if (inport_accept_i) begin
          rd_d    = 1'b0;
          wr_d    = '0;
          tmo_d   = '0;
          state_d = ST_WAIT;
        end
      end

      // Priority: DDR error, then DDR ack, then timeout expiry.
      ST_WAIT: begin
        if (!wb_cyc_i) abort_d = 1'b1;
        if (inport_error_i) begin
          buf_inval  = 1'b1;
          resp_err_d = 1'b1;
          state_d    = ST_RESP;
        end else if (inport_ack_i) begin
          if (we_q) begin
            buf_merge = 1'b1;
          end else begin
            buf_load   = 1'b1;
            resp_dat_d = lane_word(inport_read_data_i, lane_q);
          end
          resp_err_d = 1'b0;
          state_d    = ST_RESP;
        end else if (tmo_expire) begin
          buf_inval  = 1'b1;
          resp_err_d = 1'b1;
          state_d    = ST_RESP;
        end else if (tmo_q != '1) begin
          tmo_d = tmo_q + 1'b1;
        end
      end

      ST_RESP: begin
        if (bus_req && !abort_q) begin
          ack_d = !resp_err_q;
          err_d = resp_err_q;
          if (!resp_err_q) dat_d = resp_dat_q;
        end
        state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      ack_q      <= 1'b0;
      err_q      <= 1'b0;
      dat_q      <= '0;
      rd_q       <= 1'b0;
      wr_q       <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      abort_q    <= 1'b0;
      resp_err_q <= 1'b0;
      tmo_q      <= '0;
    end else begin
      state_q    <= state_d;
      ack_q      <= ack_d;
      err_q      <= err_d;
      dat_q      <= dat_d;
      rd_q       <= rd_d;
      wr_q       <= wr_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      abort_q    <= abort_d;
      resp_err_q <= resp_err_d;
      tmo_q      <= tmo_d;
    end
  end

  always_ff @(posedge clk_i) begin
    lane_q     <= lane_d;
    we_q       <= we_d;
    mask_q     <= mask_d;
    resp_dat_q <= resp_dat_d;
  end

  assign wb_ack_o            = ack_q;
  assign wb_err_o            = err_q;
  assign wb_dat_o            = dat_q;
  assign inport_rd_o         = rd_q;
  assign inport_wr_o         = wr_q;
  assign inport_addr_o       = addr_q;
  assign inport_write_data_o = wdata_q;

endmodule

// File: tb/tb_wb_ddr3_line_bridge.sv
// Bench for wb_ddr3_line_bridge: directed scenarios plus a randomized run checked
// against a line-memory and buffer-residency model.
module tb_wb_ddr3_line_bridge;

  localparam int TMO = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         cyc, stb, we;
  logic [31:0]  adr, dat_w;
  logic [3:0]   sel;
  logic         wb_ack_o, wb_err_o;
  logic [31:0]  wb_dat_o;
  logic         inport_rd_o;
  logic [15:0]  inport_wr_o;
  logic [31:0]  inport_addr_o;
  logic [127:0] inport_write_data_o;
  logic         accept, dack, derr;
  logic [127:0] rdata;

  int total = 0;
  int bad   = 0;

  int           n_ack, n_err, n_req, lat, acc_k;
  logic [31:0]  rdat, addr_seen;
  logic [15:0]  wr_seen;
  logic [127:0] wd_seen;
  logic         stable, rd_seen;

  always #5 clk = ~clk;

  wb_ddr3_line_bridge #(.ADDR_W(28), .TIMEOUT(TMO), .LINE_BUF(1)) dut (
    .clk_i               (clk),
    .rst_i               (rst),
    .wb_cyc_i            (cyc),
    .wb_stb_i            (stb),
    .wb_we_i             (we),
    .wb_adr_i            (adr),
    .wb_dat_i            (dat_w),
    .wb_sel_i            (sel),
    .wb_ack_o            (wb_ack_o),
    .wb_err_o            (wb_err_o),
    .wb_dat_o            (wb_dat_o),
    .inport_rd_o         (inport_rd_o),
    .inport_wr_o         (inport_wr_o),
    .inport_addr_o       (inport_addr_o),
    .inport_write_data_o (inport_write_data_o),
    .inport_accept_i     (accept),
    .inport_ack_i        (dack),
    .inport_error_i      (derr),
    .inport_read_data_i  (rdata)
  );

  // One bus access with a scripted DDR responder; rsp_kind 0=ack 1=error 2=silent 3=ack+error.
  // Runs a fixed 30-cycle window so extra pulses are counted. Starts and ends at a negedge.
  task automatic xfer(input logic i_we, input logic [31:0] i_adr, input logic [31:0] i_dat,
                      input logic [3:0] i_sel, input int acc_dly, input int rsp_dly,
                      input int rsp_kind, input logic [127:0] rline, input int abort_at);
    int req_cyc, wcnt;
    logic accepted, responded, active;
    n_ack = 0; n_err = 0; n_req = 0; lat = 0; acc_k = 0;
    rdat = '0; wr_seen = '0; addr_seen = '0; wd_seen = '0; stable = 1'b1; rd_seen = 1'b0;
    req_cyc = 0; wcnt = 0; accepted = 1'b0; responded = 1'b0; active = 1'b1;
    cyc = 1'b1; stb = 1'b1; we = i_we; adr = i_adr; dat_w = i_dat; sel = i_sel;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      accept = 1'b0; dack = 1'b0; derr = 1'b0;
      if (k == abort_at) begin cyc = 1'b0; stb = 1'b0; active = 1'b0; end
      if (wb_ack_o) begin n_ack++; rdat = wb_dat_o; if (lat == 0) lat = k; end
      if (wb_err_o) begin n_err++; if (lat == 0) lat = k; end
      if (active && (wb_ack_o || wb_err_o)) begin cyc = 1'b0; stb = 1'b0; active = 1'b0; end
      if (inport_rd_o || inport_wr_o != 16'h0) begin
        if (accepted) n_req++;
        else begin
          if (req_cyc == 0) begin
            rd_seen = inport_rd_o; wr_seen = inport_wr_o;
            addr_seen = inport_addr_o; wd_seen = inport_write_data_o;
          end else if (inport_rd_o !== rd_seen || inport_wr_o !== wr_seen ||
                       inport_addr_o !== addr_seen || inport_write_data_o !== wd_seen) begin
            stable = 1'b0;
          end
          req_cyc++;
          if (req_cyc > acc_dly) begin accept = 1'b1; accepted = 1'b1; n_req++; acc_k = k; end
        end
      end else if (accepted && !responded && rsp_kind != 2) begin
        wcnt++;
        if (wcnt > rsp_dly) begin
          responded = 1'b1;
          rdata = rline;
          dack = (rsp_kind == 0 || rsp_kind == 3);
          derr = (rsp_kind == 1 || rsp_kind == 3);
        end
      end
    end
    cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = 4'h0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    total++; if ({wb_ack_o, wb_err_o, inport_rd_o} !== 3'b000) begin bad++;
      $display("FAIL reset_ctrl got=%b exp=000", {wb_ack_o, wb_err_o, inport_rd_o}); end
    total++; if (inport_wr_o !== 16'h0 || inport_addr_o !== 32'h0) begin bad++;
      $display("FAIL reset_req got wr=%h addr=%h exp 0", inport_wr_o, inport_addr_o); end
    total++; if (wb_dat_o !== 32'h0 || inport_write_data_o !== 128'h0) begin bad++;
      $display("FAIL reset_data got dat=%h wdata=%h exp 0", wb_dat_o, inport_write_data_o); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_read_hit();
    logic [127:0] line;
    line = {32'h0000DDDD, 32'h0000CCCC, 32'h0000BBBB, 32'h0000AAAA};
    xfer(1'b0, 32'h14, 32'h0, 4'hF, 0, 1, 0, line, 0);
    total++; if (n_ack !== 1 || n_err !== 0) begin bad++;
      $display("FAIL miss_term got ack=%0d err=%0d exp 1/0", n_ack, n_err); end
    total++; if (n_req !== 1 || rd_seen !== 1'b1 || addr_seen !== 32'h10) begin bad++;
      $display("FAIL miss_req got n=%0d rd=%b addr=%h exp 1/1/10", n_req, rd_seen, addr_seen); end
    total++; if (rdat !== 32'h0000BBBB) begin bad++;
      $display("FAIL miss_data got=%h exp=0000bbbb", rdat); end
    xfer(1'b0, 32'h18, 32'h0, 4'hF, 0, 1, 0, 128'h0, 0);
    total++; if (n_req !== 0) begin bad++; $display("FAIL hit_noreq got=%0d exp=0", n_req); end
    total++; if (rdat !== 32'h0000CCCC || n_ack !== 1) begin bad++;
      $display("FAIL hit_data got=%h ack=%0d exp=0000cccc/1", rdat, n_ack); end
    total++; if (lat !== 2) begin bad++; $display("FAIL hit_latency got=%0d exp=2", lat); end
  endtask

  task automatic test_write_merge();
    xfer(1'b1, 32'h1C, 32'h12345678, 4'b0011, 0, 1, 0, 128'h0, 0);
    total++; if (wr_seen !== 16'h3000 || rd_seen !== 1'b0 || addr_seen !== 32'h10) begin bad++;
      $display("FAIL wr_strobe got wr=%h rd=%b addr=%h exp 3000/0/10", wr_seen, rd_seen, addr_seen); end
    total++; if (wd_seen !== {4{32'h12345678}}) begin bad++;
      $display("FAIL wr_data got=%h exp=%h", wd_seen, {4{32'h12345678}}); end
    total++; if (n_ack !== 1 || n_req !== 1) begin bad++;
      $display("FAIL wr_term got ack=%0d req=%0d exp 1/1", n_ack, n_req); end
    xfer(1'b0, 32'h1C, 32'h0, 4'hF, 0, 1, 0, 128'h0, 0);
    total++; if (n_req !== 0 || rdat !== 32'h00005678) begin bad++;
      $display("FAIL wr_merge got req=%0d dat=%h exp 0/00005678", n_req, rdat); end
  endtask

  task automatic test_accept_stall();
    logic [127:0] line;
    line = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
    xfer(1'b0, 32'h104, 32'h0, 4'hF, 5, 2, 0, line, 0);
    total++; if (stable !== 1'b1 || acc_k !== 6) begin bad++;
      $display("FAIL stall_stable got stable=%b acc=%0d exp 1/6", stable, acc_k); end
    total++; if (n_ack !== 1 || n_err !== 0 || rdat !== 32'h22222222) begin bad++;
      $display("FAIL stall_term got ack=%0d err=%0d dat=%h exp 1/0/22222222", n_ack, n_err, rdat); end
  endtask

  task automatic test_timeout();
    int late_acks;
    xfer(1'b0, 32'h200, 32'h0, 4'hF, 0, 0, 2, 128'h0, 0);
    total++; if (n_err !== 1 || n_ack !== 0) begin bad++;
      $display("FAIL tmo_term got err=%0d ack=%0d exp 1/0", n_err, n_ack); end
    // TMO wait cycles, one RESP cycle, then the pulse is visible.
    total++; if (lat !== acc_k + TMO + 2) begin bad++;
      $display("FAIL tmo_latency got=%0d exp=%0d", lat, acc_k + TMO + 2); end
    dack = 1'b1; rdata = '1;
    @(negedge clk);
    dack = 1'b0;
    late_acks = 0;
    repeat (4) begin @(negedge clk); if (wb_ack_o || wb_err_o) late_acks++; end
    total++; if (late_acks !== 0) begin bad++; $display("FAIL tmo_late_ack got=%0d exp=0", late_acks); end
    xfer(1'b0, 32'h108, 32'h0, 4'hF, 0, 0, 0, {4{32'h5A5A5A5A}}, 0);
    total++; if (n_req !== 1 || rdat !== 32'h5A5A5A5A) begin bad++;
      $display("FAIL tmo_inval got req=%0d dat=%h exp 1/5a5a5a5a", n_req, rdat); end
  endtask

  task automatic test_no_ddr_paths();
    xfer(1'b0, 32'h1000_0000, 32'h0, 4'hF, 0, 0, 0, 128'h0, 0);
    total++; if (n_err !== 1 || n_ack !== 0 || n_req !== 0 || lat !== 2) begin bad++;
      $display("FAIL oob_rd got err=%0d ack=%0d req=%0d lat=%0d exp 1/0/0/2", n_err, n_ack, n_req, lat); end
    xfer(1'b1, 32'hF000_0010, 32'hFFFF_FFFF, 4'hF, 0, 0, 0, 128'h0, 0);
    total++; if (n_err !== 1 || n_req !== 0) begin bad++;
      $display("FAIL oob_wr got err=%0d req=%0d exp 1/0", n_err, n_req); end
    xfer(1'b1, 32'h40, 32'hCAFE_F00D, 4'h0, 0, 0, 0, 128'h0, 0);
    total++; if (n_ack !== 1 || n_req !== 0 || lat !== 2) begin bad++;
      $display("FAIL zero_sel got ack=%0d req=%0d lat=%0d exp 1/0/2", n_ack, n_req, lat); end
  endtask

  task automatic test_errors();
    xfer(1'b0, 32'h300, 32'h0, 4'hF, 0, 0, 0, {4{32'h0BADBEEF}}, 0);
    xfer(1'b1, 32'h304, 32'h1, 4'hF, 1, 1, 1, 128'h0, 0);
    total++; if (n_err !== 1 || n_ack !== 0) begin bad++;
      $display("FAIL ddr_err got err=%0d ack=%0d exp 1/0", n_err, n_ack); end
    xfer(1'b0, 32'h300, 32'h0, 4'hF, 0, 0, 3, {4{32'h77777777}}, 0);
    total++; if (n_req !== 1) begin bad++; $display("FAIL err_inval got req=%0d exp=1", n_req); end
    total++; if (n_err !== 1 || n_ack !== 0) begin bad++;
      $display("FAIL err_wins got err=%0d ack=%0d exp 1/0", n_err, n_ack); end
  endtask

  task automatic test_abort();
    logic [127:0] line;
    line = {32'hA3A3A3A3, 32'hA2A2A2A2, 32'hA1A1A1A1, 32'hA0A0A0A0};
    xfer(1'b0, 32'h500, 32'h0, 4'hF, 0, 3, 0, line, 3);
    total++; if (n_ack !== 0 || n_err !== 0 || n_req !== 1) begin bad++;
      $display("FAIL abort_term got ack=%0d err=%0d req=%0d exp 0/0/1", n_ack, n_err, n_req); end
    xfer(1'b0, 32'h508, 32'h0, 4'hF, 0, 0, 0, 128'h0, 0);
    total++; if (n_req !== 0 || n_ack !== 1 || rdat !== 32'hA2A2A2A2) begin bad++;
      $display("FAIL abort_buf got req=%0d ack=%0d dat=%h exp 0/1/a2a2a2a2", n_req, n_ack, rdat); end
  endtask

  task automatic test_reset_mid();
    int acks;
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h600; sel = 4'hF;
    @(negedge clk);
    accept = 1'b1;
    @(negedge clk);
    accept = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    total++; if ({wb_ack_o, wb_err_o, inport_rd_o} !== 3'b000 || inport_wr_o !== 16'h0 ||
                 inport_addr_o !== 32'h0 || inport_write_data_o !== 128'h0 || wb_dat_o !== 32'h0) begin
      bad++; $display("FAIL reset_mid got ack=%b err=%b rd=%b addr=%h exp all 0",
                      wb_ack_o, wb_err_o, inport_rd_o, inport_addr_o); end
    rst = 1'b0; cyc = 1'b0; stb = 1'b0; dack = 1'b1; rdata = '0;
    @(negedge clk);
    dack = 1'b0;
    acks = 0;
    repeat (4) begin @(negedge clk); if (wb_ack_o || wb_err_o || inport_rd_o) acks++; end
    total++; if (acks !== 0) begin bad++; $display("FAIL reset_mid_quiet got=%0d exp=0", acks); end
  endtask

  task automatic test_random();
    logic [127:0] mem [4];
    logic [127:0] line;
    logic [15:0]  exp_wr;
    logic [31:0]  a, d, exp_dat;
    logic [3:0]   s;
    logic         w, oob, bv;
    int           li, ln, bl, e_req, e_ack, e_err;
    do_reset();
    for (int i = 0; i < 4; i++) mem[i] = {$urandom, $urandom, $urandom, $urandom};
    bv = 1'b0; bl = 0;
    for (int t = 0; t < 80; t++) begin
      li = $urandom_range(0, 3); ln = $urandom_range(0, 3);
      oob = ($urandom_range(0, 9) == 0);
      w = $urandom_range(0, 1); s = 4'($urandom_range(0, 15)); d = $urandom;
      a = 32'(li * 16 + ln * 4);
      if (oob) a = a | 32'h1000_0000;
      line = mem[li];
      exp_dat = line[ln*32 +: 32];
      exp_wr = '0;
      for (int b = 0; b < 4; b++) if (s[b]) exp_wr[ln*4 + b] = 1'b1;
      e_ack = oob ? 0 : 1; e_err = oob ? 1 : 0;
      if (oob) e_req = 0;
      else if (!w) e_req = (bv && bl == li) ? 0 : 1;
      else e_req = (s == 4'h0) ? 0 : 1;
      xfer(w, a, d, s, $urandom_range(0, 3), $urandom_range(0, 4), 0, mem[li], 0);
      total++; if (n_ack !== e_ack || n_err !== e_err) begin bad++;
        $display("FAIL rnd_term t=%0d got ack=%0d err=%0d exp %0d/%0d", t, n_ack, n_err, e_ack, e_err); end
      total++; if (n_req !== e_req) begin bad++;
        $display("FAIL rnd_req t=%0d adr=%h we=%b got=%0d exp=%0d", t, a, w, n_req, e_req); end
      if (!oob && !w) begin
        total++; if (rdat !== exp_dat) begin bad++;
          $display("FAIL rnd_rdata t=%0d adr=%h got=%h exp=%h", t, a, rdat, exp_dat); end
        bv = 1'b1; bl = li;
      end
      if (e_req == 1) begin
        total++; if (addr_seen !== 32'(li * 16) || rd_seen !== !w || wr_seen !== (w ? exp_wr : 16'h0)) begin
          bad++; $display("FAIL rnd_reqfields t=%0d got addr=%h rd=%b wr=%h exp addr=%h wr=%h",
                          t, addr_seen, rd_seen, wr_seen, li * 16, exp_wr); end
      end
      if (!oob && w && s != 4'h0) begin
        total++; if (wd_seen !== {4{d}}) begin bad++;
          $display("FAIL rnd_wdata t=%0d got=%h exp=%h", t, wd_seen, {4{d}}); end
        for (int b = 0; b < 4; b++) if (s[b]) line[ln*32 + b*8 +: 8] = d[b*8 +: 8];
        mem[li] = line;
      end
    end
  endtask

  initial begin
    rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0; adr = '0; dat_w = '0; sel = '0;
    accept = 1'b0; dack = 1'b0; derr = 1'b0; rdata = '0;
    @(negedge clk);
    test_reset();
    test_read_hit();
    test_write_merge();
    test_accept_stall();
    test_timeout();
    test_no_ddr_paths();
    test_errors();
    test_abort();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wb_ddr3_line_bridge.md
# wb_ddr3_line_bridge

Upstream bridge between the 32-bit WISHBONE classic bus and the DDR3 core's 128-bit line request port. It replaces the combinational glue in the DDR3 WISHBONE wrapper. It places word data and byte enables into the correct lane of a 16-byte line, sequences one outstanding DDR request at a time, keeps a one-line read buffer so that back-to-back word reads in the same line avoid DDR round trips, and bounds every access with a timeout.

## Interface
Parameters:
- ADDR_W, 28: implemented byte-address width; the line index is wb_adr_i[ADDR_W-1:4].
- TIMEOUT, 1023: cycles from request acceptance to wb_err_o; 0 disables the timeout.
- LINE_BUF, 1: 1 enables the read line buffer; 0 sends every read to DDR.

Ports:
- clk_i  in  1  single clock, shared with the DDR3 core clock. One clock; reset is synchronous and active-high.
- rst_i  in  1  synchronous, active-high reset.
- wb_cyc_i, wb_stb_i, wb_we_i  in  1 each  WISHBONE classic control.
- wb_adr_i  in  32  byte address.
- wb_dat_i  in  32  write data.
- wb_sel_i  in  4  byte selects.
- wb_ack_o, wb_err_o  out  1 each  single-cycle termination pulses.
- wb_dat_o  out  32  read data, valid with wb_ack_o.
- inport_rd_o  out  1  line read request.
- inport_wr_o  out  16  byte write strobes (1 = write that byte); nonzero means a write request.
- inport_addr_o  out  32  line address, {zeros, wb_adr_i[ADDR_W-1:4], 4'b0}.
- inport_write_data_o  out  128  wb_dat_i replicated into all four lanes.
- inport_accept_i  in  1  core accepted the request this cycle.
- inport_ack_i, inport_error_i  in  1 each  response pulses.
- inport_read_data_i  in  128  line read data, valid with inport_ack_i.

## Operation
- Lane = wb_adr_i[3:2]. Lane 0 is bits [31:0] / strobes [3:0].
- inport_wr_o = wb_sel_i << (4*lane).
- wb_dat_o = selected lane of the response line or of the buffer.
- FSM states: IDLE, REQ, WAIT, RESP.
- IDLE: on cyc&stb, one of four cases applies.
  - Any address bit at or above ADDR_W is set: go to RESP with error; no DDR request.
  - Read hits a valid buffer with matching tag: go to RESP with ack.
  - Write with wb_sel_i == 0: go to RESP with ack; no DDR request.
  - Otherwise: latch address, data and mask, then go to REQ.
- REQ: hold request outputs stable until inport_accept_i, then go to WAIT and clear the timeout counter.
- WAIT, on inport_ack_i:
  - Read: load the buffer with inport_read_data_i, set the tag, set valid, and return the lane.
  - Write: if the tag matches a valid buffer, merge the selected bytes into it.
  - In both cases go to RESP.
- WAIT, on inport_error_i or timeout expiry: invalidate the buffer and go to RESP with error.
- RESP: pulse wb_ack_o or wb_err_o for one cycle, only if cyc&stb are still high. Then go to IDLE.
- Abort (wb_cyc_i drops in REQ or WAIT):
  - Continue until DDR accept and ack, apply the buffer update, then suppress termination.
  - In REQ, the request stays asserted; it is never withdrawn.
- inport_ack_i or inport_error_i arriving in IDLE or REQ is ignored. Verification flags it as a protocol error.
- If ack and error arrive in the same cycle, error wins.
- If ack and timeout expiry arrive in the same cycle, ack wins.
- If a late ack arrives after a timeout, it is dropped.

## Timing
- Reset values: all outputs 0; FSM in IDLE; buffer invalid; timeout counter 0.
- Buffer hit, out-of-range access, or zero-select write: wb_ack_o/wb_err_o two cycles after stb is sampled (IDLE→RESP→pulse).
- Miss or write: request visible the cycle after stb is sampled. Termination is asserted the cycle after the edge where ack/error is sampled in WAIT.
- Only one request is outstanding at a time. Request outputs change only in IDLE.
- Timeout: with TIMEOUT = N, error is raised when N WAIT cycles pass without ack; the counter saturates.
- Reset mid-transaction returns to IDLE immediately, without termination. Any in-flight DDR response is dropped by the IDLE rule.

## Structure
- Package wb_ddr3_pkg: FSM state enum, LINE_BYTES = 16, LANES = 4, and the lane/mask helper functions.
- One sub-module, ddr3_line_buf, holding:
  - the 128-bit data register,
  - the tag and valid bit,
  - byte-merge write,
  - whole-line load,
  - hit compare.
- The FSM and timeout counter live in the top module.

## Test plan
- Read 0x0000_0014, core returns line 0x...DDDD_CCCC_BBBB_AAAA → wb_dat_o = 0xBBBB, then a read of 0x0000_0018 hits with no inport_rd_o pulse and returns 0xCCCC.
- Write 0x1234_5678, sel 4'b0011 to 0x0000_001C → inport_wr_o = 16'h3000, data replicated; a following read of 0x1C returns 0x....5678 merged from the buffer.
- Hold inport_accept_i low for 5 cycles → request outputs stable, no termination; accept then ack → exactly one wb_ack_o.
- TIMEOUT = 8, never ack → wb_err_o exactly once, 8 cycles after accept; the next read of the same line goes to DDR.
- Address 0x1000_0000 with ADDR_W = 28 → wb_err_o, inport_rd_o stays 0.
- Drop wb_cyc_i in WAIT, then ack → no wb_ack_o, FSM back in IDLE; assert rst_i in WAIT → all outputs 0 on the next cycle.
